memory_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the single-ported main memory. It shares the memory between the instruction-fetch port (IF, read-only) and the data port (DM, read/write). It drives the memory's RD/WR strobes and address/data buses for a configurable number of wait states, then returns one ACK pulse and the read data to the winning requester. It sits between the processor's fetch/load-store logic and MAIN_MEMORY.

---
 rtl/memory_arbiter_pkg.sv | 26 ++
 rtl/memory_arbiter_wait_counter.sv | 27 ++
 rtl/memory_arbiter.sv | 130 +++++++++++++
 tb/tb_memory_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10
    } state_e;

    typedef logic port_id_t;

    localparam port_id_t PORT_IF = 1'b0;
    localparam port_id_t PORT_DM = 1'b1;

    localparam int unsigned CNT_WIDTH = 4;

    // Round-robin pick: a lone requester wins, a tie goes to the port not granted last.
    function automatic port_id_t rr_pick(input logic if_req, input logic dm_req,
                                         input port_id_t last_grant);
        if (if_req && dm_req) begin
            return (last_grant == PORT_DM) ? PORT_IF : PORT_DM;
        end
        return dm_req ? PORT_DM : PORT_IF;
    endfunction

endpackage

// File: rtl/memory_arbiter_wait_counter.sv
// Loadable down-counter that times the memory wait states; saturates at zero.
module memory_arbiter_wait_counter
    import memory_arbiter_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic                 dec_i,
    input  logic [CNT_WIDTH-1:0] load_value_i,
    output logic                 zero_o
);

    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates IF and DM ports onto one single-ported memory and sequences each access
// (strobe for WAIT_STATES+1 cycles, then a one-cycle ACK to the winner).
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS = 32,
    parameter int unsigned WAIT_STATES   = 1
) (
    input  logic                     MEMORY_ARBITER_CLOCK_50,
    input  logic                     MEMORY_ARBITER_RESET_InHigh,
    input  logic                     MEMORY_ARBITER_IF_REQ_In,
    input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_IF_ADDRESS_InBUS,
    output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_IF_data_OutBUS,
    output logic                     MEMORY_ARBITER_IF_ACK_Out,
    input  logic                     MEMORY_ARBITER_DM_REQ_In,
    input  logic                     MEMORY_ARBITER_DM_WR_In,
    input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_DM_ADDRESS_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_DM_data_InBUS,
    output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_DM_data_OutBUS,
    output logic                     MEMORY_ARBITER_DM_ACK_Out,
    output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_MEM_ADDRESS_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_MEM_data_OutBUS,
    output logic                     MEMORY_ARBITER_MEM_RD_Out,
    output logic                     MEMORY_ARBITER_MEM_WR_Out,
    input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_MEM_data_InBUS
);

    state_e                   state_q;
    port_id_t                 winner_q;
    port_id_t                 last_grant_q;
    logic                     wr_q;
    logic [DATAWIDTH_BUS-1:0] addr_q;
    logic [DATAWIDTH_BUS-1:0] wdata_q;
    logic [DATAWIDTH_BUS-1:0] if_rdata_q;
    logic [DATAWIDTH_BUS-1:0] dm_rdata_q;
    logic                     if_ack_q;
    logic                     dm_ack_q;
    logic                     mem_rd_q;
    logic                     mem_wr_q;

    logic     any_req;
    port_id_t pick;
    logic     pick_wr;
    logic     cnt_load;
    logic     cnt_dec;
    logic     cnt_zero;

    always_comb begin
        any_req  = MEMORY_ARBITER_IF_REQ_In | MEMORY_ARBITER_DM_REQ_In;
        pick     = rr_pick(MEMORY_ARBITER_IF_REQ_In, MEMORY_ARBITER_DM_REQ_In, last_grant_q);
        pick_wr  = (pick == PORT_DM) && MEMORY_ARBITER_DM_WR_In;
        cnt_load = (state_q == IDLE) && any_req;
        cnt_dec  = (state_q == ACCESS) && !cnt_zero;
    end

    memory_arbiter_wait_counter u_wait_counter (
        .clk_i        (MEMORY_ARBITER_CLOCK_50),
        .rst_i        (MEMORY_ARBITER_RESET_InHigh),
        .load_i       (cnt_load),
        .dec_i        (cnt_dec),
        .load_value_i (CNT_WIDTH'(WAIT_STATES)),
        .zero_o       (cnt_zero)
    );

    always_ff @(posedge MEMORY_ARBITER_CLOCK_50 or posedge MEMORY_ARBITER_RESET_InHigh) begin
        if (MEMORY_ARBITER_RESET_InHigh) begin
            state_q      <= IDLE;
            winner_q     <= PORT_IF;
            last_grant_q <= PORT_DM;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        winner_q <= pick;
                        wr_q     <= pick_wr;
                        mem_rd_q <= !pick_wr;
                        mem_wr_q <= pick_wr;
                        state_q  <= ACCESS;
                        if (pick == PORT_DM) begin
                            addr_q  <= MEMORY_ARBITER_DM_ADDRESS_InBUS;
                            wdata_q <= MEMORY_ARBITER_DM_data_InBUS;
                        end else begin
                            addr_q  <= MEMORY_ARBITER_IF_ADDRESS_InBUS;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_zero) begin
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state_q  <= ACK;
                        if (winner_q == PORT_DM) begin
                            dm_ack_q <= 1'b1;
                            if (!wr_q) dm_rdata_q <= MEMORY_ARBITER_MEM_data_InBUS;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= MEMORY_ARBITER_MEM_data_InBUS;
                        end
                    end
                end
                ACK: begin
                    if_ack_q     <= 1'b0;
                    dm_ack_q     <= 1'b0;
                    last_grant_q <= winner_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MEMORY_ARBITER_IF_data_OutBUS     = if_rdata_q;
    assign MEMORY_ARBITER_IF_ACK_Out         = if_ack_q;
    assign MEMORY_ARBITER_DM_data_OutBUS     = dm_rdata_q;
    assign MEMORY_ARBITER_DM_ACK_Out         = dm_ack_q;
    assign MEMORY_ARBITER_MEM_ADDRESS_OutBUS = addr_q;
    assign MEMORY_ARBITER_MEM_data_OutBUS    = wdata_q;
    assign MEMORY_ARBITER_MEM_RD_Out         = mem_rd_q;
    assign MEMORY_ARBITER_MEM_WR_Out         = mem_wr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one DUT with WAIT_STATES=1, a second with WAIT_STATES=0.
module tb_memory_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req, dm_req, dm_wr;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_data, dm_data, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, dm_ack, mem_rd, mem_wr;

    logic        z_dm_req;
    logic [31:0] z_dm_addr;
    logic        z_zero_bit;
    logic [31:0] z_zero_bus;
    logic [31:0] z_if_data, z_dm_data, z_mem_addr, z_mem_wdata, z_mem_rdata;
    logic        z_if_ack, z_dm_ack, z_mem_rd, z_mem_wr;

    int n_checks = 0;
    int n_errors = 0;
    int rd_cnt = 0, wr_cnt = 0, z_rd_cnt = 0, both_cnt = 0;
    logic [31:0] wr_addr_seen = '0, wr_data_seen = '0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h1080_0800;
            32'h0000_0800: return 32'hC400_2000;
            32'h0000_0804: return 32'hC600_2001;
            32'h0000_080C: return 32'hC800_2003;
            default:       return {16'hA5A5, a[15:0]};
        endcase
    endfunction

    assign mem_rdata   = mem_model(mem_addr);
    assign z_mem_rdata = mem_model(z_mem_addr);

    memory_arbiter #(.DATAWIDTH_BUS(32), .WAIT_STATES(1)) dut (
        .MEMORY_ARBITER_CLOCK_50           (clk),
        .MEMORY_ARBITER_RESET_InHigh       (rst),
        .MEMORY_ARBITER_IF_REQ_In          (if_req),
        .MEMORY_ARBITER_IF_ADDRESS_InBUS   (if_addr),
        .MEMORY_ARBITER_IF_data_OutBUS     (if_data),
        .MEMORY_ARBITER_IF_ACK_Out         (if_ack),
        .MEMORY_ARBITER_DM_REQ_In          (dm_req),
        .MEMORY_ARBITER_DM_WR_In           (dm_wr),
        .MEMORY_ARBITER_DM_ADDRESS_InBUS   (dm_addr),
        .MEMORY_ARBITER_DM_data_InBUS      (dm_wdata),
        .MEMORY_ARBITER_DM_data_OutBUS     (dm_data),
        .MEMORY_ARBITER_DM_ACK_Out         (dm_ack),
        .MEMORY_ARBITER_MEM_ADDRESS_OutBUS (mem_addr),
        .MEMORY_ARBITER_MEM_data_OutBUS    (mem_wdata),
        .MEMORY_ARBITER_MEM_RD_Out         (mem_rd),
        .MEMORY_ARBITER_MEM_WR_Out         (mem_wr),
        .MEMORY_ARBITER_MEM_data_InBUS     (mem_rdata)
    );

    memory_arbiter #(.DATAWIDTH_BUS(32), .WAIT_STATES(0)) dut_ws0 (
        .MEMORY_ARBITER_CLOCK_50           (clk),
        .MEMORY_ARBITER_RESET_InHigh       (rst),
        .MEMORY_ARBITER_IF_REQ_In          (z_zero_bit),
        .MEMORY_ARBITER_IF_ADDRESS_InBUS   (z_zero_bus),
        .MEMORY_ARBITER_IF_data_OutBUS     (z_if_data),
        .MEMORY_ARBITER_IF_ACK_Out         (z_if_ack),
        .MEMORY_ARBITER_DM_REQ_In          (z_dm_req),
        .MEMORY_ARBITER_DM_WR_In           (z_zero_bit),
        .MEMORY_ARBITER_DM_ADDRESS_InBUS   (z_dm_addr),
        .MEMORY_ARBITER_DM_data_InBUS      (z_zero_bus),
        .MEMORY_ARBITER_DM_data_OutBUS     (z_dm_data),
        .MEMORY_ARBITER_DM_ACK_Out         (z_dm_ack),
        .MEMORY_ARBITER_MEM_ADDRESS_OutBUS (z_mem_addr),
        .MEMORY_ARBITER_MEM_data_OutBUS    (z_mem_wdata),
        .MEMORY_ARBITER_MEM_RD_Out         (z_mem_rd),
        .MEMORY_ARBITER_MEM_WR_Out         (z_mem_wr),
        .MEMORY_ARBITER_MEM_data_InBUS     (z_mem_rdata)
    );

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (mem_rd) rd_cnt++;
        if (mem_wr) begin
            wr_cnt++;
            wr_addr_seen = mem_addr;
            wr_data_seen = mem_wdata;
        end
        if (mem_rd && mem_wr) both_cnt++;
        if (z_mem_rd) z_rd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // sel: 0 = IF, 1 = DM, 2 = DM of the zero-wait-state DUT. Returns edges until ACK.
    task automatic wait_ack(input int sel, output int cyc);
        logic a;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            a = (sel == 0) ? if_ack : (sel == 1) ? dm_ack : z_dm_ack;
        end while (!a && cyc < 20);
    endtask

    int          cyc;
    logic [12:0] if_hits, dm_hits;

    initial begin
        rst = 1'b1;
        if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        z_dm_req = 1'b0; z_dm_addr = '0; z_zero_bit = 1'b0; z_zero_bus = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_if_ack",   {31'b0, if_ack}, 32'h0);
        check("rst_dm_ack",   {31'b0, dm_ack}, 32'h0);
        check("rst_mem_rd",   {31'b0, mem_rd}, 32'h0);
        check("rst_mem_wr",   {31'b0, mem_wr}, 32'h0);
        check("rst_if_data",  if_data, 32'h0);
        check("rst_dm_data",  dm_data, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_data", mem_wdata, 32'h0);
        rst = 1'b0;

        // Tie after reset: IF first, then IF re-requests and ties with waiting DM -> DM, then IF.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h000;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'h804;
        rd_cnt = 0; if_hits = '0; dm_hits = '0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (i == 8)  dm_req = 1'b0;
            if (i == 12) if_req = 1'b0;
            @(negedge clk);
            if_hits[i] = if_ack;
            dm_hits[i] = dm_ack;
            if (i == 3) check("tie_if_data", if_data, 32'h1080_0800);
            if (i == 7) check("tie_dm_data", dm_data, 32'hC600_2001);
        end
        check("tie_if_ack_cycles", {19'b0, if_hits}, 32'h0000_0808);
        check("tie_dm_ack_cycles", {19'b0, dm_hits}, 32'h0000_0080);
        check("tie_rd_strobes", rd_cnt, 32'd6);

        // DM write
        @(posedge clk); #1;
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 32'h900; dm_wdata = 32'hDEAD_BEEF;
        rd_cnt = 0; wr_cnt = 0;
        wait_ack(1, cyc);
        check("wr_latency", cyc, 32'd3);
        @(posedge clk); #1;
        dm_req = 1'b0; dm_wr = 1'b0;
        @(negedge clk);
        check("wr_ack_pulse", {31'b0, dm_ack}, 32'h0);
        check("wr_strobes", wr_cnt, 32'd2);
        check("wr_no_rd", rd_cnt, 32'd0);
        check("wr_mem_addr", wr_addr_seen, 32'h900);
        check("wr_mem_data", wr_data_seen, 32'hDEAD_BEEF);
        check("wr_dm_data_kept", dm_data, 32'hC600_2001);

        // IF-only read
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h800;
        rd_cnt = 0;
        wait_ack(0, cyc);
        check("if_latency", cyc, 32'd3);
        check("if_data", if_data, 32'hC400_2000);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        check("if_ack_pulse", {31'b0, if_ack}, 32'h0);
        check("if_rd_strobes", rd_cnt, 32'd2);

        // Back-to-back IF with REQ held
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h800;
        rd_cnt = 0; if_hits = '0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (i == 12) if_req = 1'b0;
            @(negedge clk);
            if_hits[i] = if_ack;
        end
        check("b2b_ack_cycles", {19'b0, if_hits}, 32'h0000_0888);
        check("b2b_rd_strobes", rd_cnt, 32'd6);

        // Reset in the middle of an access
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h000;
        @(posedge clk);
        @(negedge clk);
        check("mid_in_access", {31'b0, mem_rd}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_mem_rd",  {31'b0, mem_rd}, 32'h0);
        check("mid_rst_mem_wr",  {31'b0, mem_wr}, 32'h0);
        check("mid_rst_if_ack",  {31'b0, if_ack}, 32'h0);
        check("mid_rst_dm_ack",  {31'b0, dm_ack}, 32'h0);
        check("mid_rst_if_data", if_data, 32'h0);
        if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        rd_cnt = 0; if_hits = '0; dm_hits = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if_hits[i] = if_ack;
            dm_hits[i] = dm_ack;
        end
        check("post_rst_if_ack", {19'b0, if_hits}, 32'h0);
        check("post_rst_dm_ack", {19'b0, dm_hits}, 32'h0);
        check("post_rst_rd", rd_cnt, 32'd0);

        // Zero wait states: DM read
        @(posedge clk); #1;
        z_dm_req = 1'b1; z_dm_addr = 32'h80C;
        z_rd_cnt = 0;
        wait_ack(2, cyc);
        check("ws0_latency", cyc, 32'd2);
        check("ws0_data", z_dm_data, 32'hC800_2003);
        @(posedge clk); #1;
        z_dm_req = 1'b0;
        @(negedge clk);
        check("ws0_ack_pulse", {31'b0, z_dm_ack}, 32'h0);
        check("ws0_rd_strobes", z_rd_cnt, 32'd1);

        check("rd_wr_exclusive", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
